// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver that decodes ASCII hex digits into a rolling 16-bit value.
// Bytes are reassembled LSB-first; hex characters shift a nibble into oVALUE.
module uart_hex_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  output logic [7:0]  oDATA,
  output logic        oVALID,
  output logic [3:0]  oDEC,
  output logic        oDEC_VALID,
  output logic [15:0] oVALUE,
  output logic        oFRAME_ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [1:0]    sync;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          hex_ok;
  logic [3:0]    nib;

  assign rxs = sync[1];

  // Decode looks at the completed byte while the stop bit is being sampled.
  always_comb begin
    hex_ok = 1'b1;
    nib    = 4'd0;
    if (shift >= 8'h30 && shift <= 8'h39)
      nib = shift[3:0];
    else if ((shift >= 8'h41 && shift <= 8'h46) || (shift >= 8'h61 && shift <= 8'h66))
      nib = shift[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync       <= 2'b11;
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      oDATA      <= '0;
      oVALID     <= 1'b0;
      oDEC       <= '0;
      oDEC_VALID <= 1'b0;
      oVALUE     <= '0;
      oFRAME_ERR <= 1'b0;
    end else begin
      sync       <= {sync[0], RX};
      oVALID     <= 1'b0;
      oDEC_VALID <= 1'b0;
      oFRAME_ERR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_END) begin
            cnt        <= '0;
            shift[idx] <= rxs;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rxs) begin
              oDATA  <= shift;
              oVALID <= 1'b1;
              if (hex_ok) begin
                oDEC       <= nib;
                oDEC_VALID <= 1'b1;
                oVALUE     <= {oVALUE[11:0], nib};
              end
              state <= S_IDLE;
            end else begin
              oFRAME_ERR <= 1'b1;
              state      <= S_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A line stuck low must not produce a stream of bogus frames.
        S_WAIT: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_rx.sv
// Bench for uart_hex_rx: directed sequences plus random frames against a byte-level model.
module tb_uart_hex_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RX = 1'b1;
  logic [7:0]  oDATA;
  logic        oVALID;
  logic [3:0]  oDEC;
  logic        oDEC_VALID;
  logic [15:0] oVALUE;
  logic        oFRAME_ERR;

  uart_hex_rx #(.CLK_FREQ(160), .BAUD(10)) dut (
    .clk(clk), .reset(reset), .RX(RX),
    .oDATA(oDATA), .oVALID(oVALID), .oDEC(oDEC), .oDEC_VALID(oDEC_VALID),
    .oVALUE(oVALUE), .oFRAME_ERR(oFRAME_ERR)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled mid-cycle.
  int nvalid = 0, ndecv = 0, nferr = 0;
  logic [7:0] cap_data;
  logic       cap_decv;
  logic [3:0] cap_dec;
  always @(negedge clk) begin
    if (oVALID) begin
      nvalid++;
      cap_data = oDATA;
      cap_decv = oDEC_VALID;
      cap_dec  = oDEC;
    end
    if (oDEC_VALID) ndecv++;
    if (oFRAME_ERR) nferr++;
  end

  // Reference state, byte-level.
  logic [7:0]  m_data;
  logic [3:0]  m_dec;
  logic [15:0] m_value;

  function automatic bit hex_of(input int b, output logic [3:0] v);
    v = 4'd0;
    if (b >= 48 && b <= 57)  begin v = 4'(b - 48); return 1'b1; end
    if (b >= 65 && b <= 70)  begin v = 4'(b - 55); return 1'b1; end
    if (b >= 97 && b <= 102) begin v = 4'(b - 87); return 1'b1; end
    return 1'b0;
  endfunction

  task automatic bit_out(input logic v, input int n);
    RX = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".data"},  32'(oDATA),  32'(m_data));
    chk({tag, ".dec"},   32'(oDEC),   32'(m_dec));
    chk({tag, ".value"}, 32'(oVALUE), 32'(m_value));
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_ok);
    int v0, d0, f0;
    bit h;
    logic [3:0] nb;
    v0 = nvalid; d0 = ndecv; f0 = nferr;
    bit_out(1'b0, CPB);
    for (int i = 0; i < 8; i++) bit_out(b[i], CPB);
    bit_out(stop_ok, CPB);
    h = hex_of(int'(b), nb);
    if (stop_ok) begin
      chk("nvalid", 32'(nvalid - v0), 32'd1);
      chk("nferr",  32'(nferr - f0),  32'd0);
      chk("pulse_data", 32'(cap_data), 32'(b));
      chk("pulse_decv", 32'(cap_decv), 32'(h));
      chk("ndecv", 32'(ndecv - d0), 32'(h));
      m_data = b;
      if (h) begin
        m_dec   = nb;
        m_value = {m_value[11:0], nb};
      end
    end else begin
      bit_out(1'b0, 2 * CPB);
      bit_out(1'b1, CPB);
      chk("ferr_nferr",  32'(nferr - f0),  32'd1);
      chk("ferr_nvalid", 32'(nvalid - v0), 32'd0);
    end
    chk_outputs("frame");
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".data"},  32'(oDATA), 32'd0);
    chk({tag, ".vld"},   32'(oVALID), 32'd0);
    chk({tag, ".dec"},   32'(oDEC), 32'd0);
    chk({tag, ".decv"},  32'(oDEC_VALID), 32'd0);
    chk({tag, ".value"}, 32'(oVALUE), 32'd0);
    chk({tag, ".ferr"},  32'(oFRAME_ERR), 32'd0);
  endtask

  initial begin
    string hx;
    int v0, f0;
    hx = "0123456789ABCDEFabcdef";
    m_data = '0; m_dec = '0; m_value = '0;

    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    // Long idle: no pulses expected.
    v0 = nvalid; f0 = nferr;
    bit_out(1'b1, 20 * CPB);
    chk("idle_nvalid", 32'(nvalid - v0), 32'd0);
    chk("idle_nferr",  32'(nferr - f0),  32'd0);
    chk_reset_state("idle");

    // "213" back-to-back
    frame("2", 1); frame("1", 1); frame("3", 1);
    chk("val_213", 32'(oVALUE), 32'h0213);

    // Non-hex then hex with idle gaps
    frame("M", 1); bit_out(1'b1, 3 * CPB);
    frame("5", 1); bit_out(1'b1, 2 * CPB);
    frame("F", 1); bit_out(1'b1, CPB);
    frame("C", 1);
    chk("val_35fc", 32'(oVALUE), 32'h35FC);
    frame("3", 1); chk("val_5fc3", 32'(oVALUE), 32'h5FC3);
    frame("2", 1); chk("val_fc32", 32'(oVALUE), 32'hFC32);
    frame("1", 1); chk("val_c321", 32'(oVALUE), 32'hC321);

    // Framing error, then recovery
    frame("2", 0);
    frame("7", 1);
    chk("val_3217", 32'(oVALUE), 32'h3217);

    // Short glitch is a false start
    v0 = nvalid; f0 = nferr;
    bit_out(1'b0, 3);
    bit_out(1'b1, 20 * CPB);
    chk("glitch_nvalid", 32'(nvalid - v0), 32'd0);
    chk("glitch_nferr",  32'(nferr - f0),  32'd0);
    chk_outputs("glitch");

    // Reset mid-frame
    bit_out(1'b0, CPB);
    bit_out(1'b1, CPB);
    bit_out(1'b0, CPB / 2);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    RX = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_data = '0; m_dec = '0; m_value = '0;
    bit_out(1'b1, CPB);
    frame("1", 1);
    chk("val_0001", 32'(oVALUE), 32'h0001);

    // Random frames: mix of hex chars and arbitrary bytes, gaps and bad stops
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      if ($urandom_range(0, 1) == 0) b = hx[$urandom_range(0, 21)];
      else                           b = 8'($urandom_range(0, 255));
      frame(b, $urandom_range(0, 6) != 0);
      bit_out(1'b1, $urandom_range(0, 2) * CPB);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
